// File: rtl/cache_fill_fsm.sv
// Direct-mapped write-through cache. Read misses stall the CPU while a whole line
// is fetched from a pipelined fixed-latency backing memory.
module cache_fill_fsm #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 8,
    parameter int NUM_LINES  = 64,
    parameter int MEM_LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              inv,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - 1 - OFF_W - IDX_W;
    localparam int LINE_W = TAG_W + IDX_W;
    localparam int CNT_W  = OFF_W + 1;
    localparam logic [CNT_W-1:0] WORDS = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LINE_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  ret_cnt;
    logic [LINE_W-1:0] base_line;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]  tags  [NUM_LINES];
    logic [DATA_W-1:0] words [NUM_LINES*LINE_WORDS];

    logic [OFF_W-1:0]  offset;
    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit;
    logic              rd_miss;
    logic              wr_req;
    logic              issuing;
    logic              last_ret;
    logic              unused_cfg;

    assign offset   = addr[OFF_W:1];
    assign index    = addr[OFF_W+IDX_W:OFF_W+1];
    assign tag      = addr[ADDR_W-1:OFF_W+IDX_W+1];
    assign fill_idx = base_line[IDX_W-1:0];
    assign fill_tag = base_line[LINE_W-1:IDX_W];

    // Byte-address bit 0 and the memory latency play no part in this logic.
    assign unused_cfg = ^{addr[0], MEM_LAT[0]};

    assign hit      = req & valid[index] & (tags[index] == tag);
    assign rd_miss  = (state == IDLE) & req & ~wr & ~hit;
    assign wr_req   = (state == IDLE) & req & wr;
    assign issuing  = (state == FILL) & (issue_cnt < WORDS);
    assign last_ret = (state == FILL) & mem_rdata_valid & (ret_cnt == LAST);

    always_comb begin
        stall     = (state == FILL) | rd_miss;
        rdata     = '0;
        mem_req   = wr_req | issuing;
        mem_wr    = wr_req;
        mem_addr  = '0;
        mem_wdata = '0;
        if ((state == IDLE) & hit & ~wr)
            rdata = words[{index, offset}];
        if (wr_req) begin
            mem_addr  = addr;
            mem_wdata = wdata;
        end else if (issuing) begin
            mem_addr = {base_line, issue_cnt[OFF_W-1:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            valid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The victim line goes invalid at once so its half-filled words never hit.
                    if (rd_miss) begin
                        state        <= FILL;
                        valid[index] <= 1'b0;
                    end
                end
                FILL: begin
                    if (issuing)
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    if (mem_rdata_valid)
                        ret_cnt <= ret_cnt + CNT_W'(1);
                    if (last_ret) begin
                        valid[fill_idx] <= 1'b1;
                        state           <= IDLE;
                        issue_cnt       <= '0;
                        ret_cnt         <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Invalidate wins over a completing fill and aborts any fill in flight.
            if (inv) begin
                valid     <= '0;
                state     <= IDLE;
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_miss)
            base_line <= {tag, index};
        if (wr_req & hit)
            words[{index, offset}] <= wdata;
        if ((state == FILL) & mem_rdata_valid)
            words[{fill_idx, ret_cnt[OFF_W-1:0]}] <= mem_rdata;
        if (last_ret)
            tags[fill_idx] <= fill_tag;
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench for cache_fill_fsm: a pipelined backing memory plus a
// line-presence model predicting hits, stall length and fill address order.
module tb_cache_fill_fsm;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int LINE_WORDS = 8;
    localparam int NUM_LINES  = 64;
    localparam int MEM_LAT    = 4;
    localparam int STALL_LEN  = 1 + LINE_WORDS + MEM_LAT;
    localparam int LOAD_BOUND = 100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              wr = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              inv = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic              stall;
    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rdata_valid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    cache_fill_fsm #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS),
        .NUM_LINES(NUM_LINES), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .inv(inv), .rdata(rdata), .stall(stall), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Backing memory seen by the DUT, and the bench's own view of memory contents.
    logic [DATA_W-1:0] bmem    [1 << (ADDR_W-1)];
    logic [DATA_W-1:0] ref_mem [1 << (ADDR_W-1)];

    typedef struct {int due; logic [DATA_W-1:0] d;} ret_t;
    ret_t rq[$];
    int cyc = 0;

    always @(negedge clk) begin
        if (mem_req) begin
            if (mem_wr) bmem[mem_addr[ADDR_W-1:1]] = mem_wdata;
            else rq.push_back('{due: cyc + MEM_LAT, d: bmem[mem_addr[ADDR_W-1:1]]});
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = rq[0].d;
            void'(rq.pop_front());
        end else begin
            mem_rdata_valid = 1'b0;
            mem_rdata       = '0;
        end
    end

    // Line-presence model: which tag each index holds, if any.
    bit ref_valid [NUM_LINES];
    int ref_tag   [NUM_LINES];

    function automatic int idx_of(input logic [15:0] a);
        return int'(a >> 4) % NUM_LINES;
    endfunction

    function automatic bit model_hit(input logic [15:0] a);
        return ref_valid[idx_of(a)] && ref_tag[idx_of(a)] == int'(a >> 10);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NUM_LINES; i++) ref_valid[i] = 1'b0;
    endfunction

    task automatic do_load(input logic [15:0] a, input bit inv_last);
        int exp_fills, stall_cyc, nreq, nret, bad_addr;
        bit done, did_inv;
        logic [15:0] base;
        exp_fills = model_hit(a) ? 0 : (inv_last ? 2 : 1);
        base = a & ~16'(2 * LINE_WORDS - 1);
        stall_cyc = 0; nreq = 0; nret = 0; bad_addr = 0; done = 0; did_inv = 0;
        req = 1'b1; wr = 1'b0; addr = a;
        for (int c = 0; c < LOAD_BOUND && !done; c++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
            end else begin
                if (c == 0) check_eq("miss_rdata_zero", rdata, 0);
                stall_cyc++;
                if (mem_req) begin
                    if (mem_wr || mem_addr != base + 16'(2 * (nreq % LINE_WORDS))) bad_addr++;
                    nreq++;
                end
                if (mem_rdata_valid) begin
                    nret++;
                    if (inv_last && !did_inv && nret == LINE_WORDS) begin
                        inv = 1'b1;
                        did_inv = 1;
                    end
                end
                @(posedge clk);
                #1 inv = 1'b0;
            end
        end
        check_eq("load_done", done, 1);
        check_eq("load_rdata", rdata, ref_mem[a[15:1]]);
        check_eq("load_hit_memreq", mem_req, 0);
        check_eq("load_stall_cycles", stall_cyc, exp_fills * STALL_LEN);
        check_eq("load_fill_reqs", nreq, exp_fills * LINE_WORDS);
        check_eq("load_fill_addr_errs", bad_addr, 0);
        @(posedge clk);
        #1 req = 1'b0;
        if (exp_fills == 2) model_clear();
        ref_valid[idx_of(a)] = 1'b1;
        ref_tag[idx_of(a)]   = int'(a >> 10);
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d);
        req = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        check_eq("store_stall", stall, 0);
        check_eq("store_memreq", {mem_req, mem_wr}, 2'b11);
        check_eq("store_memaddr", mem_addr, a);
        check_eq("store_memwdata", mem_wdata, d);
        @(posedge clk);
        #1 req = 1'b0; wr = 1'b0;
        ref_mem[a[15:1]] = d;
    endtask

    task automatic pulse_inv();
        inv = 1'b1;
        @(posedge clk);
        #1 inv = 1'b0;
        model_clear();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, {stall, mem_req, mem_wr, mem_addr, mem_wdata, rdata}, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << (ADDR_W-1)); i++) begin
            bmem[i]    = 16'($urandom);
            ref_mem[i] = bmem[i];
        end
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_outputs");
        @(posedge clk);
        #1;

        // Cold miss, then hits across the freshly filled line.
        do_load(16'h0010, 0);
        for (int a = 16'h0012; a <= 16'h001E; a += 2) do_load(16'(a), 0);

        // Store hit, load back, store miss without allocate.
        do_store(16'h0014, 16'hBEEF);
        do_load(16'h0014, 0);
        do_store(16'h0414, 16'h1234);
        do_load(16'h0010, 0);

        // Index conflict: same index, different tag.
        do_load(16'h0410, 0);
        do_load(16'h0010, 0);

        // Reset in cycle 5 of a fill with returns still in flight.
        pulse_inv();
        req = 1'b1; wr = 1'b0; addr = 16'h0010;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1; req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        repeat (8) begin
            @(negedge clk);
            check_idle_outputs("post_reset_idle");
            @(posedge clk);
            #1;
        end
        check_eq("returns_drained", rq.size(), 0);
        do_load(16'h0010, 0);

        // Invalidate coinciding with the final return forces a second fill.
        do_load(16'h0820, 1);
        do_load(16'h0822, 0);

        for (int n = 0; n < 80; n++) begin
            logic [15:0] ra;
            int op;
            ra = 16'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) |
                     ($urandom_range(0, 7) << 1));
            op = $urandom_range(0, 9);
            if (op < 6) do_load(ra, $urandom_range(0, 7) == 0);
            else if (op < 9) do_store(ra, 16'($urandom));
            else pulse_inv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
